// File: rtl/cpu_pkg.sv
// Shared CPU encodings: load-type codes, write-back source select and data width.
package cpu_pkg;

  localparam int WB_DATA_W = 32;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LB  = 3'b001,
    LT_LBU = 3'b010,
    LT_LH  = 3'b011,
    LT_LHU = 3'b100
  } load_type_e;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension, little-endian; purely combinational.
// Unassigned load-type codes fall back to a full word.
module load_align
  import cpu_pkg::*;
(
  input  logic [2:0]           load_type,
  input  logic [1:0]           addr_lo,
  input  logic [WB_DATA_W-1:0] rdata,
  output logic [WB_DATA_W-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  load_type_e  lt;

  assign lt = load_type_e'(load_type);

  always_comb begin
    byte_lane = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      2'd3:    byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
  end

  assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (lt)
      LT_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      LT_LBU:  data = {24'd0, byte_lane};
      LT_LH:   data = {{16{half_lane[15]}}, half_lane};
      LT_LHU:  data = {16'd0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: 1-cycle capture of write-back data, one register write per instruction.
// stall holds the entry, flush bubbles it; define WB_DEBUG_EN for retired-count / last-PC outputs.
module mem_wb_stage
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [31:0]          in_pc,
  input  logic                 in_reg_we,
  input  logic                 in_wb_sel,
  input  logic [4:0]           in_rd,
  input  logic [WB_DATA_W-1:0] in_alu_result,
  input  logic [WB_DATA_W-1:0] in_mem_rdata,
  input  logic [2:0]           in_load_type,
  input  logic                 in_exception,
  output logic                 wb_we,
  output logic [4:0]           wb_addr,
  output logic [WB_DATA_W-1:0] wb_data,
  output logic                 wb_valid,
  output logic [31:0]          wb_pc,
  output logic                 fwd_hit_valid,
  output logic [4:0]           fwd_rd,
  output logic [WB_DATA_W-1:0] fwd_data
`ifdef WB_DEBUG_EN
  ,
  output logic [31:0]          dbg_retired_cnt,
  output logic [31:0]          dbg_last_pc
`endif
);

  logic                 valid_q;
  logic                 reg_we_q;
  logic                 written_q;
  logic [31:0]          pc_q;
  logic [4:0]           rd_q;
  logic [WB_DATA_W-1:0] data_q;
  logic [WB_DATA_W-1:0] align_data;
  logic [WB_DATA_W-1:0] data_next;

  load_align u_load_align (
    .load_type (in_load_type),
    .addr_lo   (in_alu_result[1:0]),
    .rdata     (in_mem_rdata),
    .data      (align_data)
  );

  assign data_next = (in_wb_sel == WB_SEL_MEM) ? align_data : in_alu_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      reg_we_q  <= 1'b0;
      written_q <= 1'b0;
      pc_q      <= '0;
      rd_q      <= '0;
      data_q    <= '0;
    end else if (flush) begin
      valid_q   <= 1'b0;
      reg_we_q  <= 1'b0;
      written_q <= 1'b0;
    end else if (stall) begin
      // The write already went out in the entry's first cycle; suppress repeats while held.
      written_q <= 1'b1;
    end else begin
      valid_q   <= in_valid;
      reg_we_q  <= in_valid & in_reg_we & ~in_exception & (in_rd != 5'd0);
      written_q <= 1'b0;
      pc_q      <= in_pc;
      rd_q      <= in_rd;
      data_q    <= data_next;
    end
  end

  assign wb_we    = valid_q & reg_we_q & ~written_q;
  assign wb_addr  = rd_q;
  assign wb_data  = data_q;
  assign wb_valid = valid_q;
  assign wb_pc    = pc_q;

  // Forwarding stays live for the whole hold, independent of the write-once flag.
  assign fwd_hit_valid = valid_q & reg_we_q & (rd_q != 5'd0);
  assign fwd_rd        = rd_q;
  assign fwd_data      = data_q;

`ifdef WB_DEBUG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_retired_cnt <= '0;
      dbg_last_pc     <= '0;
    end else if (valid_q & ~written_q) begin
      dbg_retired_cnt <= dbg_retired_cnt + 32'd1;
      dbg_last_pc     <= pc_q;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic        in_reg_we = 1'b0;
  logic        in_wb_sel = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_mem_rdata = '0;
  logic [2:0]  in_load_type = '0;
  logic        in_exception = 1'b0;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        fwd_hit_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`ifdef WB_DEBUG_EN
  logic [31:0] dbg_retired_cnt;
  logic [31:0] dbg_last_pc;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_pc         (in_pc),
    .in_reg_we     (in_reg_we),
    .in_wb_sel     (in_wb_sel),
    .in_rd         (in_rd),
    .in_alu_result (in_alu_result),
    .in_mem_rdata  (in_mem_rdata),
    .in_load_type  (in_load_type),
    .in_exception  (in_exception),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .wb_valid      (wb_valid),
    .wb_pc         (wb_pc),
    .fwd_hit_valid (fwd_hit_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data)
`ifdef WB_DEBUG_EN
    ,
    .dbg_retired_cnt (dbg_retired_cnt),
    .dbg_last_pc     (dbg_last_pc)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic we, input logic sel,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [2:0] lt, input logic exc);
    in_valid = v; in_pc = pc; in_reg_we = we; in_wb_sel = sel; in_rd = rd;
    in_alu_result = alu; in_mem_rdata = rdata; in_load_type = lt; in_exception = exc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h40, 1'b1, 1'b0, 5'd9, 32'hABCD, 32'h0, 3'd0, 1'b0);
    step();
    rst = 1'b0;
    total++;
    if ({wb_valid, wb_we, wb_addr, fwd_hit_valid} !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl got v=%b we=%b addr=%0d fwd=%b want all 0", wb_valid, wb_we, wb_addr, fwd_hit_valid);
    end
    total++;
    if ({wb_data, wb_pc} !== 64'h0) begin
      bad++; $display("FAIL reset_data got data=%h pc=%h want 0/0", wb_data, wb_pc);
    end
`ifdef WB_DEBUG_EN
    total++;
    if ({dbg_retired_cnt, dbg_last_pc} !== 64'h0) begin
      bad++; $display("FAIL reset_dbg got cnt=%0d pc=%h want 0/0", dbg_retired_cnt, dbg_last_pc);
    end
`endif
  endtask

  task automatic test_byte_loads();
    drive(1'b1, 32'h100, 1'b1, 1'b1, 5'd5, 32'h1000_0003, 32'h80FF_FF12, 3'b001, 1'b0);
    step();
    total++;
    if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd5, 32'hFFFF_FF80}) begin
      bad++; $display("FAIL lb_lane3 got we=%b addr=%0d data=%h want 1/5/ffffff80", wb_we, wb_addr, wb_data);
    end
    total++;
    if ({wb_valid, wb_pc} !== {1'b1, 32'h100}) begin
      bad++; $display("FAIL lb_pc got v=%b pc=%h want 1/00000100", wb_valid, wb_pc);
    end
    drive(1'b1, 32'h104, 1'b1, 1'b1, 5'd6, 32'h1000_0003, 32'h80FF_FF12, 3'b010, 1'b0);
    step();
    total++;
    if (wb_data !== 32'h0000_0080) begin
      bad++; $display("FAIL lbu_lane3 got %h want 00000080", wb_data);
    end
    drive(1'b1, 32'h108, 1'b1, 1'b1, 5'd6, 32'h1000_0001, 32'h80FF_FF12, 3'b001, 1'b0);
    step();
    total++;
    if (wb_data !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL lb_lane1 got %h want ffffffff", wb_data);
    end
    drive(1'b1, 32'h10C, 1'b1, 1'b1, 5'd6, 32'h1000_0000, 32'h80FF_FF12, 3'b001, 1'b0);
    step();
    total++;
    if (wb_data !== 32'h0000_0012) begin
      bad++; $display("FAIL lb_lane0 got %h want 00000012", wb_data);
    end
  endtask

  task automatic test_half_word_loads();
    drive(1'b1, 32'h200, 1'b1, 1'b1, 5'd8, 32'h2000_0002, 32'hBEEF_1234, 3'b100, 1'b0);
    step();
    total++;
    if (wb_data !== 32'h0000_BEEF) begin
      bad++; $display("FAIL lhu_hi got %h want 0000beef", wb_data);
    end
    drive(1'b1, 32'h204, 1'b1, 1'b1, 5'd8, 32'h2000_0002, 32'hBEEF_1234, 3'b011, 1'b0);
    step();
    total++;
    if (wb_data !== 32'hFFFF_BEEF) begin
      bad++; $display("FAIL lh_hi got %h want ffffbeef", wb_data);
    end
    drive(1'b1, 32'h208, 1'b1, 1'b1, 5'd8, 32'h2000_0000, 32'hBEEF_9234, 3'b011, 1'b0);
    step();
    total++;
    if (wb_data !== 32'hFFFF_9234) begin
      bad++; $display("FAIL lh_lo got %h want ffff9234", wb_data);
    end
    drive(1'b1, 32'h20C, 1'b1, 1'b1, 5'd8, 32'h2000_0002, 32'hBEEF_1234, 3'b000, 1'b0);
    step();
    total++;
    if (wb_data !== 32'hBEEF_1234) begin
      bad++; $display("FAIL lw got %h want beef1234", wb_data);
    end
    drive(1'b1, 32'h210, 1'b1, 1'b1, 5'd8, 32'h2000_0003, 32'hCAFE_F00D, 3'b111, 1'b0);
    step();
    total++;
    if (wb_data !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL lt7_as_lw got %h want cafef00d", wb_data);
    end
  endtask

  task automatic test_stall_write_once();
    int we_cycles;
    drive(1'b1, 32'h300, 1'b1, 1'b0, 5'd7, 32'h0000_1234, 32'hFFFF_FFFF, 3'b001, 1'b0);
    step();
    we_cycles = wb_we ? 1 : 0;
    total++;
    if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd7, 32'h1234}) begin
      bad++; $display("FAIL stall_first got we=%b addr=%0d data=%h want 1/7/00001234", wb_we, wb_addr, wb_data);
    end
    stall = 1'b1;
    drive(1'b1, 32'h304, 1'b1, 1'b0, 5'd9, 32'hDEAD_BEEF, 32'h0, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (wb_we) we_cycles++;
      total++;
      if ({wb_valid, wb_addr, wb_data, wb_pc} !== {1'b1, 5'd7, 32'h1234, 32'h300}) begin
        bad++; $display("FAIL stall_hold[%0d] got v=%b addr=%0d data=%h pc=%h want 1/7/00001234/00000300", i, wb_valid, wb_addr, wb_data, wb_pc);
      end
      total++;
      if ({fwd_hit_valid, fwd_rd, fwd_data} !== {1'b1, 5'd7, 32'h1234}) begin
        bad++; $display("FAIL stall_fwd[%0d] got hit=%b rd=%0d data=%h want 1/7/00001234", i, fwd_hit_valid, fwd_rd, fwd_data);
      end
    end
    total++;
    if (we_cycles != 1) begin
      bad++; $display("FAIL stall_we_count got %0d want 1", we_cycles);
    end
    stall = 1'b0;
    step();
    total++;
    if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd9, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL after_stall got we=%b addr=%0d data=%h want 1/9/deadbeef", wb_we, wb_addr, wb_data);
    end
  endtask

  task automatic test_exception_flush();
    drive(1'b1, 32'h400, 1'b1, 1'b0, 5'd3, 32'h55, 32'h0, 3'b000, 1'b1);
    step();
    total++;
    if ({wb_valid, wb_we, fwd_hit_valid} !== 3'b100) begin
      bad++; $display("FAIL exc_ctrl got v=%b we=%b fwd=%b want 1/0/0", wb_valid, wb_we, fwd_hit_valid);
    end
    total++;
    if (wb_pc !== 32'h400) begin
      bad++; $display("FAIL exc_pc got %h want 00000400", wb_pc);
    end
    flush = 1'b1;
    stall = 1'b1;
    drive(1'b1, 32'h404, 1'b1, 1'b0, 5'd4, 32'h66, 32'h0, 3'b000, 1'b0);
    step();
    flush = 1'b0;
    stall = 1'b0;
    total++;
    if ({wb_valid, wb_we, fwd_hit_valid} !== 3'b000) begin
      bad++; $display("FAIL flush_stall got v=%b we=%b fwd=%b want 0/0/0", wb_valid, wb_we, fwd_hit_valid);
    end
  endtask

  task automatic test_rd_zero_and_bubble();
    drive(1'b1, 32'h500, 1'b1, 1'b0, 5'd0, 32'h77, 32'h0, 3'b000, 1'b0);
    step();
    total++;
    if ({wb_valid, wb_we, fwd_hit_valid} !== 3'b100) begin
      bad++; $display("FAIL rd0 got v=%b we=%b fwd=%b want 1/0/0", wb_valid, wb_we, fwd_hit_valid);
    end
    drive(1'b0, 32'h504, 1'b1, 1'b0, 5'd2, 32'h88, 32'h0, 3'b000, 1'b0);
    step();
    total++;
    if ({wb_valid, wb_we, fwd_hit_valid} !== 3'b000) begin
      bad++; $display("FAIL bubble got v=%b we=%b fwd=%b want 0/0/0", wb_valid, wb_we, fwd_hit_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 32'h600, 1'b1, 1'b0, 5'd4, 32'h99, 32'h0, 3'b000, 1'b0);
    step();
    stall = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({wb_valid, wb_we, wb_addr, fwd_hit_valid, wb_data, wb_pc} !== 72'h0) begin
      bad++; $display("FAIL rst_stall got v=%b we=%b addr=%0d fwd=%b data=%h pc=%h want all 0", wb_valid, wb_we, wb_addr, fwd_hit_valid, wb_data, wb_pc);
    end
`ifdef WB_DEBUG_EN
    total++;
    if (dbg_retired_cnt !== 32'h0) begin
      bad++; $display("FAIL rst_stall_dbg got %0d want 0", dbg_retired_cnt);
    end
`endif
    step();
    total++;
    if ({wb_valid, wb_we} !== 2'b00) begin
      bad++; $display("FAIL post_rst_stall got v=%b we=%b want 0/0", wb_valid, wb_we);
    end
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_byte_loads();
    test_half_word_loads();
    test_stall_write_once();
    test_exception_flush();
    test_rd_zero_and_bubble();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port stall  input  1  hold current entry.
REQ-004 SHALL have port flush  input  1  squash current entry.
REQ-005 SHALL have port in_valid  input  1  MEM-stage instruction present.
REQ-006 SHALL have port in_pc  input  32  MEM-stage PC.
REQ-007 SHALL have port in_reg_we  input  1  instruction writes a register.
REQ-008 SHALL have port in_wb_sel  input  1  0=ALU result, 1=load data.
REQ-009 SHALL have port in_rd  input  5  destination register.
REQ-010 SHALL have port in_alu_result  input  32  ALU result / load address.
REQ-011 SHALL have port in_mem_rdata  input  32  raw memory word.
REQ-012 SHALL have port in_load_type  input  3  load width/sign code.
REQ-013 SHALL have port in_exception  input  1  MEM-stage instruction faulted.
REQ-014 SHALL have port wb_we  output  1  register-file write enable.
REQ-015 SHALL have port wb_addr  output  5  register-file write address.
REQ-016 SHALL have port wb_data  output  32  register-file write data.
REQ-017 SHALL have port wb_valid  output  1  entry occupied.
REQ-018 SHALL have port wb_pc  output  32  PC of held entry.
REQ-019 SHALL have ports fwd_hit_valid/fwd_rd/fwd_data  output  1/5/32  forwarding view: valid & reg_we & rd!=0, rd, data; independent of write-once flag.

Function
REQ-020 SHALL capture on posedge; priority rst > flush > stall > load.
REQ-021 flush SHALL clear valid (entry becomes bubble) even when stall is high.
REQ-022 stall SHALL hold every registered field unchanged.
REQ-023 Load SHALL store valid=in_valid; reg_we=in_valid & in_reg_we & ~in_exception & (in_rd!=0).
REQ-024 Data SHALL be computed at capture (latency 1 cycle): wb_sel=0 -> in_alu_result; wb_sel=1 -> aligned load data.
REQ-025 Alignment: LW 000 word; LB 001 / LBU 010 byte lane in_alu_result[1:0], little-endian, sign/zero extended; LH 011 / LHU 100 halfword lane in_alu_result[1], sign/zero extended; codes 101-111 SHALL be treated as LW.
REQ-026 wb_we SHALL equal valid & reg_we & ~written; written set on first posedge the entry is held by stall, cleared on any load/flush/rst -> one write per instruction.
REQ-027 wb_addr/wb_data SHALL present held values regardless of wb_we.
REQ-028 Faulted entry SHALL keep wb_valid=1, wb_pc valid, wb_we=0.

Reset
REQ-029 rst SHALL clear valid, reg_we, written; wb_addr=0, wb_data=0, wb_pc=0; all outputs 0 next cycle.
REQ-030 rst asserted during stall SHALL override the stall; no write issued after reset.

Configuration
REQ-031 Macro WB_DEBUG_EN defined SHALL add outputs dbg_retired_cnt[31:0] (increments once per valid entry on its first cycle, wraps at 2^32, reset 0) and dbg_last_pc[31:0] (PC of last retired entry, reset 0).
REQ-032 WB_DEBUG_EN undefined SHALL remove those ports and counter logic; other behaviour identical.

Structure
REQ-033 Load-type codes, wb_sel encoding, and WB_DATA_W=32 SHALL live in shared package cpu_pkg.
REQ-034 Lane select/extension SHALL be sub-module load_align (combinational).

Verification
REQ-035 LB addr=0x...03, rdata=0x80FF_FF12, wb_sel=1, rd=5 -> next cycle wb_we=1, wb_addr=5, wb_data=0xFFFF_FF80.
REQ-036 LHU addr=0x...02, rdata=0xBEEF_1234 -> wb_data=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
REQ-037 ALU write rd=7 data=0x1234 then stall 3 cycles -> wb_we=1 exactly one cycle, wb_data held 0x1234 throughout.
REQ-038 in_exception=1, rd=3 -> wb_valid=1, wb_we=0, fwd_hit_valid=0; flush+stall same cycle -> wb_valid=0 next cycle.
REQ-039 rd=0 ALU write -> wb_we=0; rst mid-stall -> all outputs 0, dbg_retired_cnt=0 (WB_DEBUG_EN).
